// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache.
// Fetches have one-cycle latency: the address is registered, and the lookup
// is combinational from that register in the following cycle. A miss fills
// the whole line from external memory, one acknowledged word at a time. The
// fetch stage keeps re-presenting the missed PC, so the repeated fetch then
// hits once the fill is complete.
module instruction_cache #(
    parameter int INDEX_BITS = 6,  // log2 of line count
    parameter int WORD_BITS  = 2   // log2 of 32-bit words per line
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [31:0] address_i,
    input  logic        read_i,
    output logic [31:0] data_o,
    output logic        data_ready_o,
    input  logic        flush_i,
    output logic [31:0] mem_address_o,
    output logic        mem_read_o,
    input  logic [31:0] mem_data_i,
    input  logic        mem_ack_i
);

    localparam int LINES     = 1 << INDEX_BITS;
    localparam int WORDS     = 1 << WORD_BITS;
    localparam int OFFSET    = WORD_BITS + 2;          // byte offset within a line
    localparam int TAG_BITS  = 32 - INDEX_BITS - OFFSET;
    localparam int LINE_BITS = 32 - OFFSET;            // tag + index

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [31:0]          data_mem [LINES*WORDS];
    logic [TAG_BITS-1:0]  tag_mem  [LINES];
    logic [LINES-1:0]     valid;

    // ------------------------------------------------------------------
    // Request register and fill bookkeeping
    // ------------------------------------------------------------------
    logic                  req_valid;
    logic [31:2]           req_addr;
    state_t                state;
    logic [LINE_BITS-1:0]  fill_line;    // tag+index of the line being filled
    logic [WORD_BITS-1:0]  fill_count;
    logic                  flushed;      // a flush arrived during this fill
    logic [31:0]           data_hold;

    // The byte-select bits of the fetch address never matter.
    logic unused_byte_bits;
    assign unused_byte_bits = ^address_i[1:0];

    // ------------------------------------------------------------------
    // Address split of the registered request and of the fill line
    // ------------------------------------------------------------------
    logic [WORD_BITS-1:0]  req_word;
    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] fill_index;
    logic [TAG_BITS-1:0]   fill_tag;

    assign req_word   = req_addr[OFFSET-1:2];
    assign req_index  = req_addr[OFFSET+INDEX_BITS-1:OFFSET];
    assign req_tag    = req_addr[31:OFFSET+INDEX_BITS];
    assign fill_index = fill_line[INDEX_BITS-1:0];
    assign fill_tag   = fill_line[LINE_BITS-1:INDEX_BITS];

    // ------------------------------------------------------------------
    // Lookup and control decodes
    // ------------------------------------------------------------------
    logic        hit;
    logic [31:0] hit_word;
    logic        start_fill;
    logic        fill_ack;
    logic        last_word;

    assign hit_word   = data_mem[{req_index, req_word}];
    assign hit        = req_valid && (state == IDLE) && valid[req_index]
                        && (tag_mem[req_index] == req_tag);
    assign start_fill = (state == IDLE) && req_valid && !hit && !flush_i;
    assign fill_ack   = (state == FILL) && mem_ack_i;
    assign last_word  = (fill_count == WORD_BITS'(WORDS - 1));

    // Hit data goes straight out; otherwise the last delivered word is held.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every
        // path, or synthesis infers a latch to remember the missing case.
        data_o       = data_hold;
        data_ready_o = 1'b0;
        if (hit) begin
            data_o       = hit_word;
            data_ready_o = 1'b1;
        end
    end

    // Capture the fetch request for next cycle's lookup.
    always_ff @(posedge clock_i) begin
        // NOTE: registers are updated with <= so every flop samples the values
        // from before the edge, regardless of statement order.
        req_valid <= read_i & ~reset_i;
        if (read_i) begin
            req_addr <= address_i[31:2];
        end
    end

    // Remember the most recently delivered instruction word.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            data_hold <= '0;
        end else if (hit) begin
            data_hold <= hit_word;
        end
    end

    // Fill state machine with registered memory-side outputs.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state         <= IDLE;
            fill_line     <= '0;
            fill_count    <= '0;
            flushed       <= 1'b0;
            mem_read_o    <= 1'b0;
            mem_address_o <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_fill) begin
                        state         <= FILL;
                        fill_line     <= req_addr[31:OFFSET];
                        fill_count    <= '0;
                        flushed       <= 1'b0;
                        mem_read_o    <= 1'b1;
                        mem_address_o <= {req_addr[31:OFFSET], {OFFSET{1'b0}}};
                    end
                end
                FILL: begin
                    if (flush_i) begin
                        flushed <= 1'b1;
                    end
                    if (mem_ack_i) begin
                        if (last_word) begin
                            state         <= IDLE;
                            fill_count    <= '0;
                            mem_read_o    <= 1'b0;
                            mem_address_o <= '0;
                        end else begin
                            fill_count    <= fill_count + 1'b1;
                            mem_address_o <= {fill_line,
                                              WORD_BITS'(fill_count + 1'b1),
                                              2'b00};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Valid bits: cleared by reset/flush, dropped on fill entry, set on fill end.
    always_ff @(posedge clock_i) begin
        if (reset_i || flush_i) begin
            valid <= '0;
        end else begin
            if (start_fill) begin
                valid[req_index] <= 1'b0;
            end
            if (fill_ack && last_word && !flushed) begin
                valid[fill_index] <= 1'b1;
            end
        end
    end

    // Write returned fill words and, with the last one, the line tag.
    always_ff @(posedge clock_i) begin
        // NOTE: the data and tag arrays have no reset; the valid bits alone
        // decide whether their contents may be used, so RAM macros map cleanly.
        if (fill_ack && !reset_i) begin
            data_mem[{fill_index, fill_count}] <= mem_data_i;
            if (last_word) begin
                tag_mem[fill_index] <= fill_tag;
            end
        end
    end

endmodule

// File: tb/tb_instruction_cache.sv
// Self-checking bench for instruction_cache: a line-level reference model
// predicts every output each cycle, while directed sequences walk through
// misses, hits, conflicts, wait states, flushes and reset mid-fill.
module tb_instruction_cache;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic [31:0] address_i;
    logic        read_i;
    logic [31:0] data_o;
    logic        data_ready_o;
    logic        flush_i;
    logic [31:0] mem_address_o;
    logic        mem_read_o;
    logic [31:0] mem_data_i;
    logic        mem_ack_i;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock_i = ~clock_i;

    instruction_cache dut (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
        .address_i     (address_i),
        .read_i        (read_i),
        .data_o        (data_o),
        .data_ready_o  (data_ready_o),
        .flush_i       (flush_i),
        .mem_address_o (mem_address_o),
        .mem_read_o    (mem_read_o),
        .mem_data_i    (mem_data_i),
        .mem_ack_i     (mem_ack_i)
    );

    // Backing memory contents: line 0x100 holds 0xA0..0xA3, others an address pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'h10) return 32'hA0 + 32'(a[3:2]);
        return 32'hC0DE_0000 | {16'h0, a[15:0]};
    endfunction

    assign mem_data_i = mem_word(mem_address_o);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: cache lines as arrays, a pending fill as a record
    // ------------------------------------------------------------------
    bit          m_valid [64];
    logic [21:0] m_tag   [64];
    logic [31:0] m_data  [64][4];
    bit          m_req_valid;
    logic [31:0] m_req_addr;
    bit          m_busy;
    bit          m_flushed;
    logic [31:0] m_base;
    int          m_n;
    logic [31:0] m_last;
    bit          cmp_en = 1'b0;

    function automatic bit m_hit();
        int idx;
        idx = int'(m_req_addr[9:4]);
        return m_req_valid && !m_busy && m_valid[idx] && (m_tag[idx] == m_req_addr[31:10]);
    endfunction

    function automatic logic [31:0] m_word();
        return m_data[int'(m_req_addr[9:4])][int'(m_req_addr[3:2])];
    endfunction

    task automatic model_step();
        bit h;
        int idx;
        int line;
        if (reset_i) begin
            foreach (m_valid[i]) m_valid[i] = 1'b0;
            m_busy      = 1'b0;
            m_flushed   = 1'b0;
            m_req_valid = 1'b0;
            m_n         = 0;
            m_last      = 32'h0;
        end else begin
            h   = m_hit();
            idx = int'(m_req_addr[9:4]);
            if (h) m_last = m_word();
            if (m_busy) begin
                if (mem_ack_i) begin
                    line = int'(m_base[9:4]);
                    m_data[line][m_n] = mem_word(m_base + 32'(4 * m_n));
                    if (m_n == 3) begin
                        m_busy = 1'b0;
                        m_n    = 0;
                        if (!m_flushed && !flush_i) begin
                            m_valid[line] = 1'b1;
                            m_tag[line]   = m_base[31:10];
                        end
                    end else begin
                        m_n++;
                    end
                end
                if (flush_i) m_flushed = 1'b1;
            end else if (m_req_valid && !h && !flush_i) begin
                m_busy       = 1'b1;
                m_flushed    = 1'b0;
                m_base       = m_req_addr & ~32'hF;
                m_n          = 0;
                m_valid[idx] = 1'b0;
            end
            if (flush_i) foreach (m_valid[i]) m_valid[i] = 1'b0;
            m_req_valid = read_i;
            if (read_i) m_req_addr = address_i;
        end
    endtask

    // Advance the model on every active edge.
    initial forever begin
        @(posedge clock_i);
        model_step();
    end

    // Compare DUT outputs against the model mid-cycle.
    initial forever begin
        bit h;
        @(negedge clock_i);
        if (cmp_en) begin
            h = m_hit();
            check("model data_ready_o", {31'h0, data_ready_o}, {31'h0, h});
            check("model data_o", data_o, h ? m_word() : m_last);
            check("model mem_read_o", {31'h0, mem_read_o}, {31'h0, m_busy});
            if (m_busy) check("model mem_address_o", mem_address_o, m_base + 32'(4 * m_n));
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic cycle(input bit rd, input logic [31:0] a, input bit ack, input bit fl, input bit rst);
        read_i    = rd;
        address_i = a;
        mem_ack_i = ack;
        flush_i   = fl;
        reset_i   = rst;
        @(posedge clock_i);
        @(negedge clock_i);
    endtask

    // Called while a missing request is being looked up; runs the whole fill.
    task automatic miss_and_fill(input logic [31:0] base, input logic [31:0] pres_a,
                                 input logic [31:0] pres_b, input int gap, input bit flush_last);
        logic [31:0] p;
        check("miss data_ready_o", {31'h0, data_ready_o}, 32'h0);
        cycle(1'b1, pres_a, 1'b0, 1'b0, 1'b0);
        for (int w = 0; w < 4; w++) begin
            p = (w < 2) ? pres_a : pres_b;
            for (int g = 0; g < gap; g++) begin
                check("wait mem_read_o", {31'h0, mem_read_o}, 32'h1);
                check("wait mem_address_o", mem_address_o, base + 32'(4 * w));
                check("wait data_ready_o", {31'h0, data_ready_o}, 32'h0);
                cycle(1'b1, p, 1'b0, 1'b0, 1'b0);
            end
            check("fill mem_read_o", {31'h0, mem_read_o}, 32'h1);
            check("fill mem_address_o", mem_address_o, base + 32'(4 * w));
            cycle(1'b1, p, 1'b1, (w == 3) && flush_last, 1'b0);
        end
        check("fill done mem_read_o", {31'h0, mem_read_o}, 32'h0);
    endtask

    task automatic expect_hit(input string name, input logic [31:0] word);
        check({name, " ready"}, {31'h0, data_ready_o}, 32'h1);
        check({name, " data"}, data_o, word);
        check({name, " mem_read_o"}, {31'h0, mem_read_o}, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        read_i = 0; address_i = 0; mem_ack_i = 0; flush_i = 0; reset_i = 1;
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        cmp_en = 1'b1;
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("reset data_ready_o", {31'h0, data_ready_o}, 32'h0);
        check("reset mem_read_o", {31'h0, mem_read_o}, 32'h0);
        check("reset mem_address_o", mem_address_o, 32'h0);
        check("reset data_o", data_o, 32'h0);

        // 1: cold miss on 0x100, fill, then hits
        cycle(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
        miss_and_fill(32'h100, 32'h100, 32'h100, 0, 1'b0);
        expect_hit("t1 re-fetch 0x100", 32'hA0);
        cycle(1'b1, 32'h104, 1'b0, 1'b0, 1'b0);
        expect_hit("t1 0x104", 32'hA1);

        // 2: warm line back-to-back, then an idle cycle
        cycle(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
        expect_hit("t2 0x100", 32'hA0);
        cycle(1'b1, 32'h104, 1'b0, 1'b0, 1'b0);
        expect_hit("t2 0x104", 32'hA1);
        cycle(1'b1, 32'h10C, 1'b0, 1'b0, 1'b0);
        expect_hit("t2 0x10C", 32'hA3);
        cycle(1'b0, 32'h10C, 1'b0, 1'b0, 1'b0);
        check("t2 idle ready", {31'h0, data_ready_o}, 32'h0);
        check("t2 idle data held", data_o, 32'hA3);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("t2 idle no fill", {31'h0, mem_read_o}, 32'h0);

        // 3: conflicting line 0x500 evicts 0x100, which then refills
        cycle(1'b1, 32'h500, 1'b0, 1'b0, 1'b0);
        miss_and_fill(32'h500, 32'h500, 32'h500, 0, 1'b0);
        expect_hit("t3 0x500", 32'hC0DE_0500);
        cycle(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
        miss_and_fill(32'h100, 32'h100, 32'h100, 0, 1'b0);
        expect_hit("t3 refill 0x100", 32'hA0);

        // 4: wait states, address switched mid-fill, then second miss
        cycle(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
        miss_and_fill(32'h200, 32'h200, 32'h300, 2, 1'b0);
        miss_and_fill(32'h300, 32'h300, 32'h300, 0, 1'b0);
        expect_hit("t4 0x300", 32'hC0DE_0300);
        cycle(1'b1, 32'h208, 1'b0, 1'b0, 1'b0);
        expect_hit("t4 0x208", 32'hC0DE_0208);

        // 5: flush coincident with the final ack leaves the line invalid
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
        miss_and_fill(32'h100, 32'h100, 32'h100, 0, 1'b1);
        miss_and_fill(32'h100, 32'h100, 32'h100, 0, 1'b0);
        expect_hit("t5 after refill", 32'hA0);

        // 6: reset after the second ack abandons the fill
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
        check("t6 miss", {31'h0, data_ready_o}, 32'h0);
        cycle(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
        check("t6 fill started", {31'h0, mem_read_o}, 32'h1);
        cycle(1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
        check("t6 third word addr", mem_address_o, 32'h108);
        cycle(1'b1, 32'h100, 1'b0, 1'b0, 1'b1);
        check("t6 reset mem_read_o", {31'h0, mem_read_o}, 32'h0);
        check("t6 reset data_ready_o", {31'h0, data_ready_o}, 32'h0);
        check("t6 reset mem_address_o", mem_address_o, 32'h0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("t6 stray ack mem_read_o", {31'h0, mem_read_o}, 32'h0);
        cycle(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
        miss_and_fill(32'h100, 32'h100, 32'h100, 0, 1'b0);
        expect_hit("t6 after refill", 32'hA0);

        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
